// File: rtl/rx_byte_data_split_if.sv
// Bundle of the packet-stream and line-buffer signals around rx_byte_data_split.
//
// master : the environment (lane aligner feeding words in, line buffers
//          reporting full and taking beats out).
// slave  : the splitter itself.
//
// Signals:
//   sop_i, vc_i, wc_i        packet header strobe, virtual channel, byte count
//   word_i, word_valid_i     64-bit payload word and its valid
//   word_ready_o             word accepted when valid and ready are both high
//   lbf_full_ch0/1           line buffer cannot take a beat this cycle
//   byte_bufin_ch0/1         beat data per channel
//   lbfw_wdvalid_ch0/1       beat write strobe per channel
//   lbf_lastwd_ch0/1         final beat of the line
//   wr_counter_ch0/1         beat index within the line
//   busy_o                   a line is in progress
//   protocol_err_o           one-cycle protocol error pulse
interface rx_byte_data_split_if #(
    parameter int BUF_W = 32
);
    logic             sop_i;
    logic [1:0]       vc_i;
    logic [15:0]      wc_i;
    logic [63:0]      word_i;
    logic             word_valid_i;
    logic             word_ready_o;
    logic             lbf_full_ch0;
    logic             lbf_full_ch1;
    logic [BUF_W-1:0] byte_bufin_ch0;
    logic [BUF_W-1:0] byte_bufin_ch1;
    logic             lbfw_wdvalid_ch0;
    logic             lbfw_wdvalid_ch1;
    logic             lbf_lastwd_ch0;
    logic             lbf_lastwd_ch1;
    logic [15:0]      wr_counter_ch0;
    logic [15:0]      wr_counter_ch1;
    logic             busy_o;
    logic             protocol_err_o;

    modport master (
        output sop_i, vc_i, wc_i, word_i, word_valid_i, lbf_full_ch0, lbf_full_ch1,
        input  word_ready_o, byte_bufin_ch0, byte_bufin_ch1,
               lbfw_wdvalid_ch0, lbfw_wdvalid_ch1, lbf_lastwd_ch0, lbf_lastwd_ch1,
               wr_counter_ch0, wr_counter_ch1, busy_o, protocol_err_o
    );

    modport slave (
        input  sop_i, vc_i, wc_i, word_i, word_valid_i, lbf_full_ch0, lbf_full_ch1,
        output word_ready_o, byte_bufin_ch0, byte_bufin_ch1,
               lbfw_wdvalid_ch0, lbfw_wdvalid_ch1, lbf_lastwd_ch0, lbf_lastwd_ch1,
               wr_counter_ch0, wr_counter_ch1, busy_o, protocol_err_o
    );
endinterface

// File: rtl/rx_byte_data_split.sv
// Receive-side byte data splitter.
//
// Takes one long packet (one video line) at a time as a stream of 64-bit
// words, slices each word into BUF_W-bit beats (lowest bits first) and writes
// them into the channel-0 or channel-1 line buffer picked by the virtual
// channel. Virtual channels 2 and 3 are consumed and dropped.
//
// Ports:
//   rx_clk   byte clock, sole clock
//   rst_i    asynchronous active-high reset
//   bus      rx_byte_data_split_if.slave, see the interface for signal list
module rx_byte_data_split #(
    parameter int NO_LANE = 4,
    parameter int RX_GEAR = 8,
    parameter int BUF_W   = NO_LANE * RX_GEAR
) (
    input  logic                  rx_clk,
    input  logic                  rst_i,
    rx_byte_data_split_if.slave   bus
);
    localparam int BB    = BUF_W / 8;          // bytes per beat
    localparam int K     = 64 / BUF_W;         // beats per word
    localparam int SEL_W = (K > 1) ? $clog2(K) : 1;
    localparam int BB_SH = $clog2(BB);

    if (!(BUF_W == 16 || BUF_W == 32 || BUF_W == 64)) begin : g_bad_buf_w
        $error("rx_byte_data_split: BUF_W must be 16, 32 or 64");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DROP} state_t;

    state_t           state_q, state_d;
    logic [63:0]      hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             chan_q, chan_d;
    logic [16:0]      n_q, n_d;
    logic [16:0]      beat_idx_q, beat_idx_d;
    logic [16:0]      drop_cnt_q, drop_cnt_d;
    logic [BUF_W-1:0] byte_bufin_ch0_q, byte_bufin_ch0_d;
    logic [BUF_W-1:0] byte_bufin_ch1_q, byte_bufin_ch1_d;
    logic             wdvalid_ch0_q, wdvalid_ch0_d;
    logic             wdvalid_ch1_q, wdvalid_ch1_d;
    logic             lastwd_ch0_q, lastwd_ch0_d;
    logic             lastwd_ch1_q, lastwd_ch1_d;
    logic [15:0]      wr_counter_ch0_q, wr_counter_ch0_d;
    logic [15:0]      wr_counter_ch1_q, wr_counter_ch1_d;
    logic             err_q, err_d;

    logic             sel_full;
    logic             fire;
    logic             word_last;
    logic             line_last;
    logic             word_ready;
    logic             accept;
    logic [BUF_W-1:0] beat_data;
    logic [BUF_W-1:0] beats [K];

    // Beat gi of the held word sits at bits [gi*BUF_W +: BUF_W].
    for (genvar gi = 0; gi < K; gi++) begin : g_beat
        assign beats[gi] = hold_q[gi*BUF_W +: BUF_W];
    end

    assign beat_data = beats[sel_q];
    assign sel_full  = chan_q ? bus.lbf_full_ch1 : bus.lbf_full_ch0;
    assign fire      = (state_q == S_RUN) && hold_valid_q && !sel_full;
    assign word_last = (sel_q == SEL_W'(K - 1));
    assign line_last = (beat_idx_q == n_q - 17'd1);
    assign accept    = bus.word_valid_i && word_ready;

    // State register
    always_ff @(posedge rx_clk or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            hold_q           <= '0;
            hold_valid_q     <= 1'b0;
            sel_q            <= '0;
            chan_q           <= 1'b0;
            n_q              <= '0;
            beat_idx_q       <= '0;
            drop_cnt_q       <= '0;
            byte_bufin_ch0_q <= '0;
            byte_bufin_ch1_q <= '0;
            wdvalid_ch0_q    <= 1'b0;
            wdvalid_ch1_q    <= 1'b0;
            lastwd_ch0_q     <= 1'b0;
            lastwd_ch1_q     <= 1'b0;
            wr_counter_ch0_q <= '0;
            wr_counter_ch1_q <= '0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            hold_q           <= hold_d;
            hold_valid_q     <= hold_valid_d;
            sel_q            <= sel_d;
            chan_q           <= chan_d;
            n_q              <= n_d;
            beat_idx_q       <= beat_idx_d;
            drop_cnt_q       <= drop_cnt_d;
            byte_bufin_ch0_q <= byte_bufin_ch0_d;
            byte_bufin_ch1_q <= byte_bufin_ch1_d;
            wdvalid_ch0_q    <= wdvalid_ch0_d;
            wdvalid_ch1_q    <= wdvalid_ch1_d;
            lastwd_ch0_q     <= lastwd_ch0_d;
            lastwd_ch1_q     <= lastwd_ch1_d;
            wr_counter_ch0_q <= wr_counter_ch0_d;
            wr_counter_ch1_q <= wr_counter_ch1_d;
            err_q            <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.sop_i && bus.wc_i != 16'd0)
                        state_d = bus.vc_i[1] ? S_DROP : S_RUN;
            S_RUN:  if (fire && line_last) state_d = S_IDLE;
            S_DROP: if (accept && drop_cnt_q <= 17'd1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs. The last line beat never re-opens ready: the line is
    // finished, so a word offered then belongs to no line.
    always_comb begin
        word_ready = 1'b0;
        case (state_q)
            S_RUN:   word_ready = !hold_valid_q || (fire && word_last && !line_last);
            S_DROP:  word_ready = 1'b1;
            default: word_ready = 1'b0;
        endcase
    end

    // Datapath: hold register, beat selection and registered beat outputs
    always_comb begin
        hold_d           = hold_q;
        hold_valid_d     = hold_valid_q;
        sel_d            = sel_q;
        chan_d           = chan_q;
        n_d              = n_q;
        beat_idx_d       = beat_idx_q;
        drop_cnt_d       = drop_cnt_q;
        byte_bufin_ch0_d = byte_bufin_ch0_q;
        byte_bufin_ch1_d = byte_bufin_ch1_q;
        wdvalid_ch0_d    = 1'b0;
        wdvalid_ch1_d    = 1'b0;
        lastwd_ch0_d     = 1'b0;
        lastwd_ch1_d     = 1'b0;
        wr_counter_ch0_d = wr_counter_ch0_q;
        wr_counter_ch1_d = wr_counter_ch1_q;
        err_d            = (state_q == S_IDLE) ? bus.word_valid_i : bus.sop_i;

        case (state_q)
            S_IDLE: begin
                if (bus.sop_i && bus.wc_i != 16'd0) begin
                    if (!bus.vc_i[1]) begin
                        chan_d       = bus.vc_i[0];
                        // 17-bit add so wc = 0xFFFF rounds up without wrapping
                        n_d          = ({1'b0, bus.wc_i} + 17'(BB - 1)) >> BB_SH;
                        beat_idx_d   = '0;
                        hold_valid_d = 1'b0;
                        sel_d        = '0;
                        if (bus.vc_i[0]) wr_counter_ch1_d = '0;
                        else             wr_counter_ch0_d = '0;
                    end else begin
                        drop_cnt_d = ({1'b0, bus.wc_i} + 17'd7) >> 3;
                    end
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (chan_q) begin
                        byte_bufin_ch1_d = beat_data;
                        wdvalid_ch1_d    = 1'b1;
                        lastwd_ch1_d     = line_last;
                        wr_counter_ch1_d = beat_idx_q[15:0];
                    end else begin
                        byte_bufin_ch0_d = beat_data;
                        wdvalid_ch0_d    = 1'b1;
                        lastwd_ch0_d     = line_last;
                        wr_counter_ch0_d = beat_idx_q[15:0];
                    end
                    beat_idx_d = beat_idx_q + 17'd1;
                    // Line end drops whatever beats are left in the held word
                    if (line_last || word_last) begin
                        hold_valid_d = 1'b0;
                        sel_d        = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
                if (accept) begin
                    hold_d       = bus.word_i;
                    hold_valid_d = 1'b1;
                    sel_d        = '0;
                end
            end
            S_DROP: begin
                if (accept) drop_cnt_d = drop_cnt_q - 17'd1;
            end
            default: ;
        endcase
    end

    assign bus.word_ready_o     = word_ready;
    assign bus.busy_o           = (state_q != S_IDLE);
    assign bus.protocol_err_o   = err_q;
    assign bus.byte_bufin_ch0   = byte_bufin_ch0_q;
    assign bus.byte_bufin_ch1   = byte_bufin_ch1_q;
    assign bus.lbfw_wdvalid_ch0 = wdvalid_ch0_q;
    assign bus.lbfw_wdvalid_ch1 = wdvalid_ch1_q;
    assign bus.lbf_lastwd_ch0   = lastwd_ch0_q;
    assign bus.lbf_lastwd_ch1   = lastwd_ch1_q;
    assign bus.wr_counter_ch0   = wr_counter_ch0_q;
    assign bus.wr_counter_ch1   = wr_counter_ch1_q;
endmodule
